// File: rtl/credit_tx_pkg.sv
// Shared widths and types for the credit link (transmitter and remote pop-count encoder).
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package credit_tx_pkg;

    // Default link geometry; instances override via parameters.
    localparam int CREDITS_DEF = 32;
    localparam int RET_MAX_DEF = 1;

    // Width needed to hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int CNTW_DEF = cnt_w(CREDITS_DEF);
    localparam int RETW_DEF = cnt_w(RET_MAX_DEF);

    // Credit count and credit return types at the default geometry.
    // The remote receiver's pop-count encoder uses credit_ret_t so both ends agree.
    typedef logic [CNTW_DEF-1:0] credit_cnt_t;
    typedef logic [RETW_DEF-1:0] credit_ret_t;

endpackage

// File: rtl/credit_tx_if.sv
// Producer handshake, link launch and credit return bundled for the credit transmitter.
// Latency: n/a (wires only).
// Backpressure: in_ready from the transmitter; the link side has no ready.
interface credit_tx_if #(
    parameter int DATAW = 32,
    parameter int RETW  = 1
);
    logic             in_valid;
    logic [DATAW-1:0] in_data;
    logic             in_ready;
    logic             tx_valid;
    logic [DATAW-1:0] tx_data;
    logic [RETW-1:0]  credit_ret;

    // Transmitter side.
    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output tx_valid,
        output tx_data,
        input  credit_ret
    );

    // Environment side: producer, remote FIFO push and pop-count return.
    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  tx_valid,
        input  tx_data,
        output credit_ret
    );
endinterface

// File: rtl/credit_tx_credit_counter.sv
// Credit up/down counter: -1 per send, +0..INC_MAX per return, saturating at MAXV.
// Latency: count updates on the clock edge after dec/inc; flags come from the registered count.
// Backpressure: none; the caller gates dec with zero so underflow is impossible.
module credit_counter #(
    parameter int MAXV    = 32,
    parameter int INC_MAX = 1,
    parameter int ALM     = 1,
    parameter int CNTW    = 6,
    parameter int INCW    = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            dec,
    input  logic [INCW-1:0] inc,
    output logic [CNTW-1:0] cnt,
    output logic            zero,
    output logic            alm,
    output logic            full
);
    localparam int              CW1       = CNTW + 1;
    localparam logic [CNTW:0]   MAX_W     = CW1'(MAXV);
    localparam logic [CNTW-1:0] MAX_N     = MAX_W[CNTW-1:0];
    localparam logic [CNTW-1:0] ALM_N     = CNTW'(ALM);
    localparam logic [INCW-1:0] INC_MAX_N = INCW'(INC_MAX);

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic [CNTW:0]   sum;
    logic            ovf;
    logic            inc_bad;

    // Next count computed one bit wider so a return that overshoots is visible, then clamped.
    always_comb begin
        sum     = {1'b0, cnt_q} - CW1'(dec) + CW1'(inc);
        ovf     = (sum > MAX_W);
        inc_bad = (inc > INC_MAX_N);
        cnt_d   = ovf ? MAX_N : sum[CNTW-1:0];
    end

    // Count register; reset means every remote slot is free again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= MAX_N;
        end else begin
            assert (!ovf) else $warning("credit overflow");
            assert (!inc_bad) else $warning("credit return above RET_MAX");
            cnt_q <= cnt_d;
        end
    end

    // Status flags from the registered count only, so in_ready never sees a same-cycle return.
    always_comb begin
        cnt  = cnt_q;
        zero = (cnt_q == '0);
        full = (cnt_q == MAX_N);
        // A single-slot link is always "almost empty" of credits.
        alm  = (MAXV == 1) ? 1'b1 : (cnt_q <= ALM_N);
    end

endmodule

// File: rtl/credit_tx.sv
// Credit-flow transmitter: valid/ready producer in, registered ready-less push to a remote FIFO out.
// Latency: 1 cycle from accept to tx_valid/tx_data.
// Backpressure: in_ready drops when the credit count is zero; returns re-open it the cycle after.
module credit_tx
    import credit_tx_pkg::*;
#(
    parameter int DATAW       = 32,
    parameter int CREDITS     = CREDITS_DEF,
    parameter int RET_MAX     = RET_MAX_DEF,
    parameter int ALM_CREDITS = 1,
    parameter int CNTW        = cnt_w(CREDITS),
    parameter int RETW        = cnt_w(RET_MAX)
) (
    input  logic             clk,
    input  logic             reset,
    credit_tx_if.master      link,
    output logic [CNTW-1:0]  credits,
    output logic             no_credit,
    output logic             alm_no_credit,
    output logic             idle
);
    logic             send;
    logic             full;
    logic             tx_valid_q;
    logic [DATAW-1:0] tx_data_q;

    // Acceptance uses only the registered count; no bypass of this cycle's returns.
    always_comb begin
        link.in_ready = !no_credit;
        send          = link.in_valid && !no_credit;
    end

    credit_counter #(
        .MAXV    (CREDITS),
        .INC_MAX (RET_MAX),
        .ALM     (ALM_CREDITS),
        .CNTW    (CNTW),
        .INCW    (RETW)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .dec   (send),
        .inc   (link.credit_ret),
        .cnt   (credits),
        .zero  (no_credit),
        .alm   (alm_no_credit),
        .full  (full)
    );

    // Output register: one push per accepted word; data holds between pushes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_valid_q <= send;
            if (send) begin
                tx_data_q <= link.in_data;
            end
        end
    end

    // Link drive and idle: all credits home and nothing sitting in the output register.
    always_comb begin
        link.tx_valid = tx_valid_q;
        link.tx_data  = tx_data_q;
        idle          = full && !tx_valid_q;
    end

endmodule

// File: doc/credit_tx.md
Name: credit_tx

Overview:
- Transmit end of a credit-flow-controlled link whose receive end is a fixed-depth FIFO queue (depth CREDITS, power of 2) in another clock-synchronous partition.
- Accepts words from a local producer over valid/ready and launches them on a registered, ready-less link.
- Tracks remote FIFO occupancy with a credit counter, so the remote queue never receives a push when full.
- Credits come back as pop-count pulses from the remote FIFO's pop side.

Parameters:
- DATAW, 32, payload width.
- CREDITS, 32, remote FIFO depth = initial credit count; must be power of 2, >= 1.
- RET_MAX, 1, max credits returned in one cycle; 1 <= RET_MAX <= CREDITS.
- ALM_CREDITS, 1, alm_no_credit threshold; 0 < ALM_CREDITS < CREDITS (ignored when CREDITS == 1).
- CNTW, CLOG2(CREDITS+1), credit counter width.
- RETW, CLOG2(RET_MAX+1), credit return width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer word valid.
- in_data  in  DATAW  producer word.
- in_ready  out  1  block can accept a word this cycle.
- tx_valid  out  1  link word valid; this is the remote FIFO push.
- tx_data  out  DATAW  link word.
- credit_ret  in  RETW  credits returned this cycle (remote pops).
- credits  out  CNTW  current credit count.
- no_credit  out  1  credits == 0.
- alm_no_credit  out  1  credits <= ALM_CREDITS.
- idle  out  1  all credits home and nothing in flight on the output register.

Behaviour:
- Reset asserted (reset == 0), asynchronously:
  - credits = CREDITS, tx_valid = 0, tx_data = 0.
  - in_ready = 1, no_credit = 0, alm_no_credit = 0 (for CREDITS == 1: alm_no_credit = 1), idle = 1.
- Reset mid-operation: in-flight tx_valid is dropped and the count returns to CREDITS. The remote FIFO must be reset in the same event; the bench resets both together.
- in_ready = (credits != 0). It depends on registered state only; credits returned this cycle are not bypassed.
- send = in_valid && in_ready.
- Launch latency: 1 cycle.
  - tx_valid <= send.
  - tx_data <= in_data when send; otherwise it holds its last value.
  - tx_valid is high for exactly one cycle per accepted word. Back-to-back sends give consecutive tx_valid cycles.
- Credit arithmetic is done at CNTW+1 bits: next = credits - send + credit_ret.
  - Send and return in the same cycle net correctly. Example: credits = 0 with credit_ret = 1 and no send gives next = 1, and in_ready rises the following cycle.
  - Overflow (next > CREDITS): RUNTIME_ASSERT "credit overflow", and the count saturates at CREDITS.
  - credit_ret > RET_MAX: RUNTIME_ASSERT.
  - Underflow cannot occur, because send requires credits != 0.
- Flags are derived from the registered count:
  - no_credit = (credits == 0).
  - alm_no_credit = (credits <= ALM_CREDITS).
  - idle = (credits == CREDITS) && !tx_valid.
- in_valid may drop without handshake; it carries no ordering obligation. in_data is sampled only on send.
- Ordering: words appear on tx_data in acceptance order; the block does no reordering or buffering beyond the single output register.
- CREDITS == 1: in_ready alternates, with at most one word outstanding until its credit returns.

Decomposition:
- Shared package: credit count type (CNTW) and credit return type (RETW) as localparam/typedef, so the remote receiver's pop-count encoder shares widths.
- One natural sub-module, credit_counter.
  - Contents: up/down counter with multi-unit increment, saturation, the assert, and the zero/almost flags.
  - Structure: it mirrors the existing pending-size counter, with decrement of 1 and increment of up to RET_MAX.
- Top level: handshake, output register, idle.

Test Plan (CREDITS=4, RET_MAX=2, ALM_CREDITS=1, DATAW=8):
- Reset release, no traffic:
  - credits = 4, in_ready = 1, idle = 1, tx_valid = 0.
  - reset pulsed low asynchronously mid-cycle → outputs return to these values before the next edge.
- Burst and exhaust: in_valid held with data 0x11..0x15, no returns.
  - tx_valid high on 4 consecutive cycles, each 1 cycle after its accept, carrying 0x11..0x14.
  - credits goes 4→0; alm_no_credit rises at credits = 1; in_ready = 0 after the 4th accept.
  - 0x15 is held off.
- Unblock: with credits = 0, pulse credit_ret = 1.
  - Next cycle credits = 1, in_ready = 1; 0x15 is accepted, then tx_data = 0x15 one cycle later.
- Simultaneous send and return: credits = 2, send, credit_ret = 2 in the same cycle → credits = 3.
- Drain: after the last send, return all outstanding credits (mix of 2 and 1 per cycle) → credits = 4, idle = 1 the cycle after the final return.
- Error injection: credits = 4, credit_ret = 1 → assertion fires, credits stays 4.
